oled_spi_streamer: RTL and testbench

//  SSD1306 128x64 OLED transmitter; the consumer end of the pixelAddress/pixelData interface.

---
 rtl/oled_spi_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_oled_spi_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_streamer.sv
// SSD1306 128x64 OLED SPI transmitter: powers up and resets the panel, sends the init
// command ROM, then streams 1024-byte frames fetched through pixelAddress/pixelData.
`timescale 1ns/1ps
module oled_spi_streamer #(
  parameter int STARTUP_WAIT = 10_000_000,
  parameter int RESET_HOLD   = 270,
  parameter int CLK_DIV      = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       frame_done
);

  localparam int WAIT_MAX = (STARTUP_WAIT > RESET_HOLD) ? STARTUP_WAIT : RESET_HOLD;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_WAIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       CMD_COUNT    = 4'd15;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_RST_HOLD,
    S_POST_RST,
    S_LOAD_CMD,
    S_SEND,
    S_BYTE_END,
    S_FETCH,
    S_LATCH
  } state_t;

  // Display off, clocking, mux 64, no offset, charge pump on, horizontal mode, remap, on.
  function automatic logic [7:0] cmd_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hAE;
      4'd1:    return 8'hD5;
      4'd2:    return 8'h80;
      4'd3:    return 8'hA8;
      4'd4:    return 8'h3F;
      4'd5:    return 8'hD3;
      4'd6:    return 8'h00;
      4'd7:    return 8'h40;
      4'd8:    return 8'h8D;
      4'd9:    return 8'h14;
      4'd10:   return 8'h20;
      4'd11:   return 8'h00;
      4'd12:   return 8'hA1;
      4'd13:   return 8'hC8;
      4'd14:   return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [3:0]       r_cmd_idx;
  logic             r_data_mode;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_phase_b;
  logic             r_sclk;
  logic             r_sdin;
  logic             r_cs;
  logic             r_dc;
  logic             r_rst_n;
  logic [9:0]       r_addr;
  logic             r_frame_done;
  logic [7:0]       w_rom_byte;

  assign w_rom_byte = cmd_rom(r_cmd_idx);

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_PWR_WAIT;
      r_wait_cnt   <= '0;
      r_cmd_idx    <= '0;
      r_data_mode  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_phase_b    <= 1'b0;
      r_sclk       <= 1'b1;
      r_sdin       <= 1'b0;
      r_cs         <= 1'b1;
      r_dc         <= 1'b0;
      r_rst_n      <= 1'b1;
      r_addr       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_PWR_WAIT: begin
          if (r_wait_cnt == STARTUP_LAST) begin
            r_wait_cnt <= '0;
            r_rst_n    <= 1'b0;
            r_state    <= S_RST_HOLD;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_RST_HOLD: begin
          if (r_wait_cnt == HOLD_LAST) begin
            r_wait_cnt <= '0;
            r_rst_n    <= 1'b1;
            r_state    <= S_POST_RST;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_POST_RST: begin
          if (r_wait_cnt == STARTUP_LAST) begin
            r_wait_cnt <= '0;
            r_cs       <= 1'b0;
            r_state    <= S_LOAD_CMD;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_LOAD_CMD: begin
          r_shift   <= w_rom_byte;
          r_sdin    <= w_rom_byte[7];
          r_dc      <= 1'b0;
          r_cmd_idx <= r_cmd_idx + 4'd1;
          r_sclk    <= 1'b0;
          r_bit_cnt <= 3'd7;
          r_div_cnt <= '0;
          r_phase_b <= 1'b0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!r_phase_b) begin
              r_phase_b <= 1'b1;
              r_sclk    <= 1'b1;
            end else if (r_bit_cnt == 3'd0) begin
              r_cs    <= 1'b1;
              r_state <= S_BYTE_END;
            end else begin
              r_phase_b <= 1'b0;
              r_sclk    <= 1'b0;
              r_shift   <= {r_shift[6:0], 1'b0};
              r_sdin    <= r_shift[6];
              r_bit_cnt <= r_bit_cnt - 3'd1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_BYTE_END: begin
          // cs drops again immediately so the panel sees a single high cycle between bytes.
          r_cs <= 1'b0;
          if (r_data_mode) begin
            r_addr       <= r_addr + 10'd1;
            r_frame_done <= (r_addr == 10'd1023);
            r_state      <= S_FETCH;
          end else if (r_cmd_idx == CMD_COUNT) begin
            r_data_mode <= 1'b1;
            r_state     <= S_FETCH;
          end else begin
            r_state <= S_LOAD_CMD;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_shift   <= pixelData;
          r_sdin    <= pixelData[7];
          r_dc      <= 1'b1;
          r_sclk    <= 1'b0;
          r_bit_cnt <= 3'd7;
          r_div_cnt <= '0;
          r_phase_b <= 1'b0;
          r_state   <= S_SEND;
        end
        default: r_state <= S_PWR_WAIT;
      endcase
    end
  end

  assign io_sclk      = r_sclk;
  assign io_sdin      = r_sdin;
  assign io_cs        = r_cs;
  assign io_dc        = r_dc;
  assign io_reset     = r_rst_n;
  assign pixelAddress = r_addr;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Bench for oled_spi_streamer: a timeline model of the whole output waveform, checked
// every cycle, plus an SPI decoder whose captured bytes and edge times are pinned by literals.
`timescale 1ns/1ps
module tb_oled_spi_streamer;

  localparam int STARTUP_WAIT = 20;
  localparam int RESET_HOLD   = 4;
  localparam int CLK_DIV      = 1;
  localparam int BIT_LEN      = 2 * CLK_DIV;
  localparam int T_CMD0       = 2 * STARTUP_WAIT + RESET_HOLD;  // first LOAD cycle
  localparam int CMD_LEN      = 8 * BIT_LEN + 2;                 // LOAD + SEND + BYTE_END
  localparam int T_DATA0      = T_CMD0 + 15 * CMD_LEN;           // first FETCH cycle
  localparam int BYTE_LEN     = 8 * BIT_LEN + 3;                 // FETCH + LATCH + SEND + BYTE_END
  localparam logic [15:0] RESET_OBS = 16'hE000;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_sclk, io_sdin, io_cs, io_dc, io_reset, frame_done;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;

  oled_spi_streamer #(
    .STARTUP_WAIT(STARTUP_WAIT),
    .RESET_HOLD  (RESET_HOLD),
    .CLK_DIV     (CLK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .io_sclk     (io_sclk),
    .io_sdin     (io_sdin),
    .io_cs       (io_cs),
    .io_dc       (io_dc),
    .io_reset    (io_reset),
    .pixelAddress(pixelAddress),
    .pixelData   (pixelData),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [15] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                           8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hAF};
  logic [7:0] lut [1024];

  // Pixel source: registered lookup, valid one cycle after the address.
  always @(posedge clk) pixelData <= lut[pixelAddress];

  int n_checks = 0;
  int n_errors = 0;
  int ticks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs t cycles after reset release; m marks the fields that matter then.
  // Layout: {io_reset, io_cs, io_sclk, io_sdin, io_dc, frame_done, pixelAddress}.
  function automatic void model_at(input int t, output logic [15:0] e, output logic [15:0] m);
    logic       rst_o, cs, sclk, sdin, dc, fd, cmp_sd;
    logic [9:0] addr;
    logic [7:0] b;
    int         k, o, n, j;
    rst_o = 1'b1; cs = 1'b1; sclk = 1'b1; sdin = 1'b0; dc = 1'b0; fd = 1'b0;
    addr = '0; cmp_sd = 1'b1;
    if (t >= STARTUP_WAIT && t < STARTUP_WAIT + RESET_HOLD) rst_o = 1'b0;
    if (t >= T_CMD0 && t < T_DATA0) begin
      k = (t - T_CMD0) / CMD_LEN;
      o = (t - T_CMD0) % CMD_LEN;
      cs = (o == CMD_LEN - 1);
      cmp_sd = (t == T_CMD0);
      if (o >= 1 && o <= 8 * BIT_LEN) begin
        j = o - 1;
        b = rom[k];
        sclk = ((j % BIT_LEN) >= CLK_DIV);
        sdin = b[7 - j / BIT_LEN];
        dc = 1'b0;
        cmp_sd = 1'b1;
      end
    end else if (t >= T_DATA0) begin
      n = (t - T_DATA0) / BYTE_LEN;
      o = (t - T_DATA0) % BYTE_LEN;
      addr = 10'(n % 1024);
      cs = (o == BYTE_LEN - 1);
      fd = (o == 0 && n > 0 && (n % 1024) == 0);
      cmp_sd = 1'b0;
      if (o >= 2 && o < 2 + 8 * BIT_LEN) begin
        j = o - 2;
        b = lut[n % 1024];
        sclk = ((j % BIT_LEN) >= CLK_DIV);
        sdin = b[7 - j / BIT_LEN];
        dc = 1'b1;
        cmp_sd = 1'b1;
      end
    end
    e = {rst_o, cs, sclk, sdin, dc, fd, addr};
    m = {3'b111, cmp_sd, cmp_sd, 11'h7FF};
  endfunction

  // Compare process: every cycle, sampled on the falling edge.
  initial begin : compare
    int t;
    logic [15:0] obs, e, m;
    t = 0;
    forever begin
      @(negedge clk);
      obs = {io_reset, io_cs, io_sclk, io_sdin, io_dc, frame_done, pixelAddress};
      if (reset) begin
        check("reset_state", 32'(obs), 32'(RESET_OBS));
        t = 0;
      end else begin
        model_at(t, e, m);
        check($sformatf("cycle%0d", t), 32'(obs & m), 32'(e & m));
        t++;
      end
    end
  end

  // SPI decoder and event recorder, cleared by every reset.
  logic [7:0] dec_bytes [$];
  logic       dec_dc [$];
  int         cs_falls [$];
  int         fd_times [$];

  initial begin : decoder
    logic [7:0] sh;
    logic       prev_sclk, prev_cs;
    int         bit_n, dec_t;
    sh = '0; prev_sclk = 1'b1; prev_cs = 1'b1; bit_n = 0; dec_t = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        dec_bytes.delete(); dec_dc.delete(); cs_falls.delete(); fd_times.delete();
        prev_sclk = 1'b1; prev_cs = 1'b1; bit_n = 0; dec_t = 0;
      end else begin
        if (!io_cs && io_sclk && !prev_sclk) begin
          sh = {sh[6:0], io_sdin};
          bit_n++;
          if (bit_n == 8) begin
            dec_bytes.push_back(sh);
            dec_dc.push_back(io_dc);
            bit_n = 0;
          end
        end
        if (prev_cs && !io_cs) cs_falls.push_back(dec_t);
        if (frame_done) fd_times.push_back(dec_t);
        prev_sclk = io_sclk;
        prev_cs = io_cs;
        dec_t++;
      end
    end
  end

  function automatic logic [7:0] byte_at(input int i);
    return (i < dec_bytes.size()) ? dec_bytes[i] : 8'hxx;
  endfunction
  function automatic logic dc_at(input int i);
    return (i < dec_dc.size()) ? dec_dc[i] : 1'bx;
  endfunction
  function automatic int fall_at(input int i);
    return (i < cs_falls.size()) ? cs_falls[i] : -1;
  endfunction
  function automatic int fd_at(input int i);
    return (i < fd_times.size()) ? fd_times[i] : -1;
  endfunction

  task automatic advance_to(input int target);
    while (ticks < target) begin
      @(posedge clk);
      ticks++;
    end
    #2;
  endtask

  task automatic check_init_sequence(input string tag);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("%s_cmd%0d", tag, i), 32'(byte_at(i)), 32'(rom[i]));
      check($sformatf("%s_cmd%0d_dc", tag, i), 32'(dc_at(i)), 32'd0);
    end
    check({tag, "_first_cs_fall"}, 32'(fall_at(0)), 32'd44);
    check({tag, "_last_cmd_cs_fall"}, 32'(fall_at(14)), 32'd296);
    check({tag, "_data_cs_fall"}, 32'(fall_at(15)), 32'd314);
  endtask

  initial begin : stimulus
    int hold;
    reset = 1'b1;
    ticks = 0;
    for (int a = 0; a < 1024; a++) lut[a] = 8'(a) ^ 8'h5A;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Abort somewhere in power-up or init, then restart cleanly.
    advance_to($urandom_range(5, 300));
    reset = 1'b1;
    #1;
    check("abort_cs", 32'(io_cs), 32'd1);
    check("abort_io_reset", 32'(io_reset), 32'd1);
    hold = $urandom_range(1, 4);
    repeat (hold) @(posedge clk);
    #2 reset = 1'b0;
    ticks = 0;

    // Init bytes and the first data byte.
    advance_to(T_DATA0 + BYTE_LEN + 1);
    check_init_sequence("init");
    check("data0", 32'(byte_at(15)), 32'h5A);
    check("data0_dc", 32'(dc_at(15)), 32'd1);
    check("data_cs_gap", 32'(fall_at(16) - fall_at(15)), 32'd19);

    // Two complete frames.
    advance_to(T_DATA0 + 2 * 1024 * BYTE_LEN + 4);
    check("data300", 32'(byte_at(15 + 300)), 32'h76);
    check("frame2_data0", 32'(byte_at(15 + 1024)), 32'h5A);
    check("frame2_data0_dc", 32'(dc_at(15 + 1024)), 32'd1);
    check("frame_done_count", 32'(fd_times.size()), 32'd2);
    check("frame_done_first", 32'(fd_at(0)), 32'd19770);
    check("frame_done_gap", 32'(fd_at(1) - fd_at(0)), 32'd19456);
    check("byte_total", 32'(dec_bytes.size()), 32'd2063);

    // Reset during bit 3 of data byte 500 (third frame).
    advance_to(T_DATA0 + 2548 * BYTE_LEN + 10);
    check("pre_abort_addr", 32'(pixelAddress), 32'd500);
    check("pre_abort_cs", 32'(io_cs), 32'd0);
    check("pre_abort_sclk", 32'(io_sclk), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_data_cs", 32'(io_cs), 32'd1);
    check("abort_data_addr", 32'(pixelAddress), 32'd0);
    hold = $urandom_range(1, 4);
    repeat (hold) @(posedge clk);
    for (int a = 0; a < 1024; a++) lut[a] = 8'($urandom);
    #2 reset = 1'b0;
    ticks = 0;

    // Full restart with random pixel content.
    advance_to(T_DATA0 + 40 * BYTE_LEN);
    check_init_sequence("restart");
    check("restart_data0", 32'(byte_at(15)), 32'(lut[0]));
    check("restart_data39", 32'(byte_at(15 + 39)), 32'(lut[39]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
